// File: rtl/hex_pkg.sv
// Shared constants and the ASCII hex decoder for the hex line parser.
package hex_pkg;

   localparam logic [1:0] KIND_DATA = 2'd0;
   localparam logic [1:0] KIND_EOL  = 2'd1;
   localparam logic [1:0] KIND_ERR  = 2'd2;

   localparam logic [7:0] ERR_BAD = 8'd1;
   localparam logic [7:0] ERR_ODD = 8'd2;
   localparam logic [7:0] ERR_OVF = 8'd3;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_SP = 8'h20;

   // Returns {is_hex, nibble}; nibble is zero for non-hex characters.
   function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39) begin
         r = {1'b1, 4'(c - 8'h30)};
      end else if (c >= 8'h41 && c <= 8'h46) begin
         r = {1'b1, 4'(c - 8'h37)};
      end else if (c >= 8'h61 && c <= 8'h66) begin
         r = {1'b1, 4'(c - 8'h57)};
      end
      return r;
   endfunction

endpackage

// File: rtl/token_fifo.sv
// Synchronous token FIFO; a push is accepted when not full or when popping the same cycle.
// Head is forced to zero while empty so outputs read zero after reset.
module token_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   cnt_q;
   logic          do_pop, do_push;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/hex_line_parser.sv
// Parses CR/LF-terminated ASCII hex lines into DATA/EOL/ERR tokens, one registered stage
// into a small FIFO; a full FIFO turns the line into an overflow error.
module hex_line_parser
   import hex_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_LINE = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_kind,
   output logic [7:0] out_data,
   output logic       busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LO      = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [3:0] nib_q, nib_d;
   logic       err_pend_q, err_pend_d;
   logic [7:0] err_code_q, err_code_d;
   logic       line_done_q, line_done_d;

   logic [4:0] dec;
   logic       is_hex, is_eol, is_sp;
   logic       fifo_full, fifo_empty, fifo_pop, fifo_push, can_push;
   logic [9:0] fifo_din, fifo_head;
   logic       raise;
   logic [7:0] raise_code;

   assign dec    = ascii_to_nibble(rx_data);
   assign is_hex = dec[4];
   assign is_eol = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
   assign is_sp  = (rx_data == ASCII_SP);

   assign fifo_pop = out_ready && !fifo_empty;
   assign can_push = !fifo_full || fifo_pop;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      nib_d       = nib_q;
      err_pend_d  = err_pend_q;
      err_code_d  = err_code_q;
      line_done_d = line_done_q;
      fifo_push   = 1'b0;
      fifo_din    = '0;
      raise       = 1'b0;
      raise_code  = '0;
      case (state_q)
         S_IDLE: if (rx_valid) begin
            if (is_hex) begin
               nib_d   = dec[3:0];
               state_d = S_LO;
            end else if (is_eol) begin
               if (count_q != 8'd0) begin
                  if (can_push) begin
                     fifo_push = 1'b1;
                     fifo_din  = {KIND_EOL, count_q};
                     count_d   = 8'd0;
                  end else begin
                     raise      = 1'b1;
                     raise_code = ERR_OVF;
                  end
               end
            end else if (!is_sp) begin
               raise      = 1'b1;
               raise_code = ERR_BAD;
            end
         end
         S_LO: if (rx_valid) begin
            if (is_hex) begin
               if (count_q == 8'(MAX_LINE) || !can_push) begin
                  raise      = 1'b1;
                  raise_code = ERR_OVF;
               end else begin
                  fifo_push = 1'b1;
                  fifo_din  = {KIND_DATA, nib_q, dec[3:0]};
                  count_d   = count_q + 8'd1;
                  state_d   = S_IDLE;
               end
            end else begin
               raise      = 1'b1;
               raise_code = (is_sp || is_eol) ? ERR_ODD : ERR_BAD;
            end
         end
         S_DISCARD: begin
            if (err_pend_q && can_push) begin
               fifo_push  = 1'b1;
               fifo_din   = {KIND_ERR, err_code_q};
               err_pend_d = 1'b0;
            end
            if (rx_valid && is_eol) begin
               count_d     = 8'd0;
               line_done_d = 1'b1;
            end
            // Leave only once the line has ended and the ERR token is in the FIFO.
            if ((line_done_q || (rx_valid && is_eol)) && (!err_pend_q || can_push)) begin
               state_d     = S_IDLE;
               line_done_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // An error caused by the terminator itself already closes the line.
      if (raise) begin
         state_d     = S_DISCARD;
         err_pend_d  = 1'b1;
         err_code_d  = raise_code;
         line_done_d = is_eol;
         if (is_eol) count_d = 8'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         count_q     <= 8'd0;
         nib_q       <= 4'd0;
         err_pend_q  <= 1'b0;
         err_code_q  <= 8'd0;
         line_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         nib_q       <= nib_d;
         err_pend_q  <= err_pend_d;
         err_code_q  <= err_code_d;
         line_done_q <= line_done_d;
      end
   end

   token_fifo #(.DEPTH(DEPTH), .W(10)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign out_valid = !fifo_empty;
   assign out_kind  = fifo_head[9:8];
   assign out_data  = fifo_head[7:0];
   assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_hex_line_parser.sv
// Directed bench for hex_line_parser: tokens are logged as {kind, data} on accepted handshakes.
module tb_hex_line_parser;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [1:0] out_kind;
   logic [7:0] out_data;
   logic       busy;

   int total = 0;
   int bad   = 0;
   logic [9:0] got[$];

   hex_line_parser #(.DEPTH(4), .MAX_LINE(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_kind  (out_kind),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (!RST && out_valid && out_ready) got.push_back({out_kind, out_data});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] c);
      @(posedge CLK); #1;
      rx_valid = 1'b1;
      rx_data  = c;
      @(posedge CLK); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(posedge CLK); #1;
      RST = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h41;
      repeat (3) @(posedge CLK);
      #1 rx_valid = 1'b0;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_kind !== 2'd0) begin bad++; $display("FAIL reset_kind got=%0d want=0", out_kind); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
   endtask

   task automatic test_basic();
      logic [9:0] exp [3];
      bit ok;
      exp = '{10'h01A, 10'h02B, 10'h102};
      got.delete();
      out_ready = 1'b1;
      send_str("1A 2b");
      send_byte(8'h0D);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_idle busy still high"); end
      total++; if (got.size() !== 3) begin bad++; $display("FAIL basic_count got=%0d want=3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp[i]) begin bad++; $display("FAIL basic_tok%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_empty_lines();
      bit ok;
      got.delete();
      out_ready = 1'b1;
      send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h0D); send_byte(8'h0A);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL empty_idle busy still high"); end
      total++; if (got.size() !== 0) begin bad++; $display("FAIL empty_count got=%0d want=0", got.size()); end
   endtask

   task automatic test_latency();
      bit ok;
      got.delete();
      out_ready = 1'b0;
      send_byte(8'h35);
      @(negedge CLK);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_half got=%b want=0", out_valid); end
      send_byte(8'h41);
      @(negedge CLK);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", out_valid); end
      total++; if ({out_kind, out_data} !== 10'h05A) begin bad++; $display("FAIL lat_tok got=%h want=05a", {out_kind, out_data}); end
      repeat (3) @(negedge CLK);
      total++; if ({out_valid, out_kind, out_data} !== 11'h45A) begin bad++; $display("FAIL lat_hold got=%h want=45a", {out_valid, out_kind, out_data}); end
      out_ready = 1'b1;
      send_byte(8'h0A);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL lat_idle busy still high"); end
      total++; if (got.size() !== 2) begin bad++; $display("FAIL lat_count got=%0d want=2", got.size()); end
      if (got.size() == 2) begin
         total++; if (got[1] !== 10'h101) begin bad++; $display("FAIL lat_eol got=%h want=101", got[1]); end
      end
   endtask

   task automatic test_bad_char();
      logic [9:0] exp [3];
      bit ok;
      exp = '{10'h201, 10'h012, 10'h101};
      got.delete();
      out_ready = 1'b1;
      send_str("1G3"); send_byte(8'h0D);
      send_str("12");  send_byte(8'h0D);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL badc_idle busy still high"); end
      total++; if (got.size() !== 3) begin bad++; $display("FAIL badc_count got=%0d want=3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp[i]) begin bad++; $display("FAIL badc_tok%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_odd_nibble();
      logic [9:0] exp [2];
      bit ok;
      exp = '{10'h012, 10'h202};
      got.delete();
      out_ready = 1'b1;
      send_str("123"); send_byte(8'h0D);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL odd_idle busy still high"); end
      total++; if (got.size() !== 2) begin bad++; $display("FAIL odd_count got=%0d want=2", got.size()); end
      for (int i = 0; i < 2 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp[i]) begin bad++; $display("FAIL odd_tok%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_fifo_full();
      logic [9:0] exp [5];
      bit ok;
      exp = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h203};
      got.delete();
      out_ready = 1'b0;
      send_str("0102030405"); send_byte(8'h0D);
      @(negedge CLK);
      total++; if ({out_valid, busy, out_data} !== 10'h301) begin bad++; $display("FAIL full_head got=%h want=301", {out_valid, busy, out_data}); end
      repeat (3) @(negedge CLK);
      out_ready = 1'b1;
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL full_idle busy still high"); end
      total++; if (got.size() !== 5) begin bad++; $display("FAIL full_count got=%0d want=5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp[i]) begin bad++; $display("FAIL full_tok%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_max_line();
      bit ok;
      int nbad;
      got.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 33; i++) send_str("00");
      send_byte(8'h0D);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL max_idle busy still high"); end
      total++; if (got.size() !== 33) begin bad++; $display("FAIL max_count got=%0d want=33", got.size()); end
      nbad = 0;
      for (int i = 0; i < 32 && i < got.size(); i++) if (got[i] !== 10'h000) nbad++;
      total++; if (nbad !== 0) begin bad++; $display("FAIL max_data wrong_tokens=%0d want=0", nbad); end
      if (got.size() == 33) begin
         total++; if (got[32] !== 10'h203) begin bad++; $display("FAIL max_err got=%h want=203", got[32]); end
      end
   endtask

   task automatic test_reset_midline();
      logic [9:0] exp [2];
      bit ok;
      exp = '{10'h0CD, 10'h101};
      got.delete();
      out_ready = 1'b0;
      send_str("ABC");
      @(negedge CLK);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstm_pre got=%b want=1", out_valid); end
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL rstm_clear got=%b want=00", {out_valid, busy}); end
      @(posedge CLK); #1 RST = 1'b0;
      out_ready = 1'b1;
      send_str("CD"); send_byte(8'h0D);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL rstm_idle busy still high"); end
      total++; if (got.size() !== 2) begin bad++; $display("FAIL rstm_count got=%0d want=2", got.size()); end
      for (int i = 0; i < 2 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp[i]) begin bad++; $display("FAIL rstm_tok%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_lines();
      test_latency();
      test_bad_char();
      test_odd_nibble();
      test_fifo_full();
      test_max_line();
      test_reset_midline();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
